// File: rtl/hilo_div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: quotient to lo, remainder to hi.
// One quotient bit per cycle; divide-by-zero short-circuits to a one-cycle result.
module hilo_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             signed_div,
   input  logic             annul,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             result_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {StIdle, StDivZero, StOn, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quot;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   always_comb begin
      // One restoring step on {rem, quot}
      shifted   = {rem_q, quot_q[WIDTH-1]};
      trial     = shifted - {1'b0, dvsr_q};
      step_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_quot = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

      a_mag = (signed_div && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
      b_mag = (signed_div && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvsr_d  = dvsr_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               qneg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
               rneg_d = signed_div & a[WIDTH-1];
               quot_d = a_mag;
               rem_d  = '0;
               dvsr_d = b_mag;
               cnt_d  = '0;
               if (b == '0) begin
                  state_d = StDivZero;
                  lo_d    = '1;
                  hi_d    = a;
               end else begin
                  state_d = StOn;
               end
            end
         end
         StOn: begin
            rem_d  = step_rem;
            quot_d = step_quot;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StDone;
               lo_d    = qneg_q ? ({WIDTH{1'b0}} - step_quot) : step_quot;
               hi_d    = rneg_q ? ({WIDTH{1'b0}} - step_rem) : step_rem;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone, StDivZero: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Flush wins over everything, including a start in the same cycle
      if (annul) begin
         state_d = StIdle;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign result_ready = (state_q == StDone) || (state_q == StDivZero);
   assign hi           = hi_q;
   assign lo           = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: vector table plus hand-written annul/reset sequences.
module tb_hilo_div_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        result_ready;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;

   hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .signed_div   (signed_div),
      .annul        (annul),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .result_ready (result_ready),
      .hi           (hi),
      .lo           (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge: that cycle is cycle 0 (accept cycle).
   task automatic run_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                         input int annul_at, input int extra1, input int extra2,
                         output int rdy_cyc, output int rdy_cnt, output int busy_cnt,
                         output logic [31:0] lo_o, output logic [31:0] hi_o);
      rdy_cyc = -1;
      rdy_cnt = 0;
      busy_cnt = 0;
      lo_o = 'x;
      hi_o = 'x;
      for (int c = 0; c <= 40; c++) begin
         start = (c == 0) || (c == extra1) || (c == extra2);
         annul = (c == annul_at);
         if (c == 0) begin
            signed_div = sd;
            a = av;
            b = bv;
         end else begin
            signed_div = ~sd;
            a = 32'hDEAD_BEEF;
            b = 32'h0000_0003;
         end
         @(negedge clk);
         if (result_ready) begin
            rdy_cnt++;
            rdy_cyc = c;
            lo_o = lo;
            hi_o = hi;
         end
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      annul = 1'b0;
   endtask

   vec_t vecs[9];
   int rc, rn, bc;
   logic [31:0] lo_v, hi_v;
   logic [31:0] prev_lo, prev_hi;

   initial begin
      vecs[0] = '{1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          33};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
      vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      vecs[4] = '{1'b0, 32'h1234_5678,  32'h0000_0010,  32'h0123_4567,  32'd8,          33};
      vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
      vecs[6] = '{1'b0, 32'h0000_ABCD,  32'd0,          32'hFFFF_FFFF,  32'h0000_ABCD,  1};
      vecs[7] = '{1'b1, 32'h8000_0001,  32'd0,          32'hFFFF_FFFF,  32'h8000_0001,  1};
      vecs[8] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          33};

      #12;
      @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_ready", {31'd0, result_ready}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         run_op(vecs[i].sd, vecs[i].a, vecs[i].b, -1, -1, -1, rc, rn, bc, lo_v, hi_v);
         check($sformatf("v%0d_ready_count", i), rn, 1);
         check($sformatf("v%0d_ready_cycle", i), rc, vecs[i].lat);
         check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat);
         check($sformatf("v%0d_lo", i), lo_v, vecs[i].lo);
         check($sformatf("v%0d_hi", i), hi_v, vecs[i].hi);
      end
      prev_lo = 32'd14;
      prev_hi = 32'd2;

      // Annul in cycle 10: back to idle in cycle 11, no result, hi/lo kept
      run_op(1'b0, 32'd100, 32'd7, 10, -1, -1, rc, rn, bc, lo_v, hi_v);
      check("annul_no_ready", rn, 0);
      check("annul_busy_cycles", bc, 10);
      @(negedge clk);
      check("annul_lo_kept", lo, prev_lo);
      check("annul_hi_kept", hi, prev_hi);
      @(posedge clk);
      #1;

      // start and annul together are not accepted
      start = 1'b1;
      annul = 1'b1;
      signed_div = 1'b0;
      a = 32'd5;
      b = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      annul = 1'b0;
      @(negedge clk);
      check("start_annul_busy", {31'd0, busy}, 32'd0);
      check("start_annul_ready", {31'd0, result_ready}, 32'd0);
      check("start_annul_lo", lo, prev_lo);
      @(posedge clk);
      #1;

      // Extra start pulses while busy are ignored
      run_op(1'b0, 32'd100, 32'd7, -1, 5, 20, rc, rn, bc, lo_v, hi_v);
      check("ignore_ready_count", rn, 1);
      check("ignore_ready_cycle", rc, 33);
      check("ignore_lo", lo_v, 32'd14);
      check("ignore_hi", hi_v, 32'd2);

      // Make hi/lo distinct from zero before the reset test
      run_op(1'b0, 32'd100, 32'd7, -1, -1, -1, rc, rn, bc, lo_v, hi_v);

      // Asynchronous reset in the middle of cycle 15
      start = 1'b1;
      signed_div = 1'b0;
      a = 32'd100;
      b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, result_ready}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      rn = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (result_ready || busy) rn++;
      end
      check("rst_no_result_after", rn, 0);
      @(posedge clk);
      #1;
      run_op(1'b0, 32'd100, 32'd7, -1, -1, -1, rc, rn, bc, lo_v, hi_v);
      check("post_rst_ready_cycle", rc, 33);
      check("post_rst_lo", lo_v, 32'd14);
      check("post_rst_hi", hi_v, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle iterative divider for MIPS DIV/DIVU.
- Produces the quotient (LO) and remainder (HI) that feed the ALU's hi/lo inputs and the HI/LO register write-back path.
- Sits in the EX stage beside the ALU. The pipeline stalls while busy=1 and writes HI/LO on the single result_ready pulse.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is required to be supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request a divide this cycle
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- annul  input  1  abort the current/pending operation (exception flush)
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- busy  output  1  operation in progress; EX must stall
- result_ready  output  1  one-cycle pulse; hi/lo are valid this cycle
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn); it acts immediately regardless of clk.
- Reset values:
  - State IDLE; counter 0; all internal operand registers 0.
  - busy=0, result_ready=0, hi=0, lo=0.
- States: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - busy=0.
  - Start is accepted when start=1 and annul=0 at a rising edge. At that edge, a, b and signed_div are latched.
  - If b==0, go to DIVZERO; otherwise go to ON with counter=0.
  - Later changes to a, b or signed_div do not affect the operation in flight.
- Signed setup:
  - When signed_div=1, the operands are replaced by their absolute values.
  - Quotient sign = a[31]^b[31].
  - Remainder sign = a[31].
- ON:
  - busy=1.
  - One restoring step per cycle:
    - Shift the {rem, quot} register left by 1.
    - Trial subtract the divisor magnitude from the upper WIDTH+1 bits.
    - If the result is non-negative, keep it and set quot LSB to 1; otherwise restore and set quot LSB to 0.
  - Counter increments each step. After WIDTH steps (counter==WIDTH-1 at the edge), go to DONE.
- DONE:
  - busy=1, result_ready=1 for exactly this one cycle.
  - hi/lo are updated at the edge entering DONE, with signs applied: lo = quot negated if the quotient sign is 1; hi = rem negated if the remainder sign is 1.
  - Next edge: go to IDLE.
  - start is not accepted in DONE; the pipeline releases the stall first.
- DIVZERO:
  - busy=1, result_ready=1 for one cycle.
  - lo=32'hFFFFFFFF, hi=latched a (raw, no sign processing).
  - Next edge: go to IDLE.
- Latency: counting the accept cycle as cycle 0, result_ready=1 in cycle 33 for a normal divide and in cycle 1 for divide-by-zero.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap); no trap.
- hi/lo hold their last values at all times except the DONE/DIVZERO update. They are never cleared by annul.
- annul=1 at any edge, in any state: go to IDLE next edge, no result_ready, hi/lo unchanged. Annul has priority over start in the same cycle.
- start while busy=1 (ON/DONE/DIVZERO) is ignored.
- Reset asserted mid-operation: immediately go to IDLE with all outputs at reset values. No result is produced after release.
- The counter never exceeds WIDTH-1, so there is no wrap-around.

Test Plan:
- Unsigned: start, signed_div=0, a=7, b=2 -> busy=1 cycles 1..33; result_ready only in cycle 33 with lo=3, hi=1.
- Signed: a=0xFFFFFFF9 (-7), b=2 -> cycle 33: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned with the same operands -> lo=0x7FFFFFFC, hi=1.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then a=0x12345678, b=0x00000010 unsigned -> lo=0x01234567, hi=8.
- Divide by zero: a=0x0000ABCD, b=0 -> result_ready in cycle 1, lo=0xFFFFFFFF, hi=0x0000ABCD, busy=0 in cycle 2.
- Annul/stall: start 100/7, annul at cycle 10 -> IDLE at cycle 11, no result_ready, hi/lo keep their prior values. start+annul in the same cycle -> not accepted. start pulses at cycles 5 and 20 of an operation -> ignored, result correct.
- Reset mid-op: start 100/7, drop resetn at cycle 15 asynchronously (between edges) -> busy, result_ready, hi, lo go to 0 before the next edge. After release, no result_ready appears; a new 100/7 gives lo=14, hi=2 at cycle 33.
